// File: rtl/l2_port_arbiter.sv
// Shares one L2/memory request port between the I-L1 (port 0) and D-L1 (port 1), round-robin, one transaction in flight.
// Latency: request pulse to mem_req_valid is 2 edges; mem_res_valid to pX_res_ready is 1 edge; one IDLE cycle between transactions.
// Backpressure: mem_req_valid and its fields hold until mem_req_ready; each port queues 2 requests and drops (sticky overflow) beyond that.

module l2_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o
);
    // Small generic FIFO: head is visible combinationally, pop must only be asserted when non-empty.
    // Latency: a push is visible at the head one edge later.
    // Backpressure: full_o is reported; a push while full is accepted only together with a pop.

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok;

    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign push_ok    = push_i && (!full_o || pop_i);
    assign head_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push_ok && pop_i) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end
endmodule

module l2_port_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int LINE_W     = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [LINE_W-1:0] p0_req_data,
    input  logic              p0_req_rw,
    input  logic              p0_req_valid,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [LINE_W-1:0] p1_req_data,
    input  logic              p1_req_rw,
    input  logic              p1_req_valid,
    output logic [LINE_W-1:0] p0_res_data,
    output logic              p0_res_ready,
    output logic [LINE_W-1:0] p1_res_data,
    output logic              p1_res_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    output logic              mem_req_rw,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    input  logic [LINE_W-1:0] mem_res_data,
    input  logic              mem_res_valid,
    output logic              grant,
    output logic              busy,
    output logic              overflow
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic              rw;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic              last_q;
    logic              grant_q;
    logic              busy_q;
    logic              overflow_q;
    logic [ADDR_W-1:0] mem_req_addr_q;
    logic [LINE_W-1:0] mem_req_data_q;
    logic              mem_req_rw_q;
    logic              mem_req_valid_q;
    logic [LINE_W-1:0] p0_res_data_q;
    logic [LINE_W-1:0] p1_res_data_q;
    logic              p0_res_ready_q;
    logic              p1_res_ready_q;

    req_t p0_in, p1_in, head0, head1, head_sel;
    logic empty0, empty1, full0, full1;
    logic start, sel, pop0, pop1, ovf0, ovf1;

    assign p0_in = '{addr: p0_req_addr, data: p0_req_data, rw: p0_req_rw};
    assign p1_in = '{addr: p1_req_addr, data: p1_req_data, rw: p1_req_rw};

    l2_arb_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk_i      (sys_clk),
        .rst_ni     (rstn),
        .push_i     (p0_req_valid),
        .pop_i      (pop0),
        .push_dat_i (p0_in),
        .head_dat_o (head0),
        .empty_o    (empty0),
        .full_o     (full0)
    );

    l2_arb_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk_i      (sys_clk),
        .rst_ni     (rstn),
        .push_i     (p1_req_valid),
        .pop_i      (pop1),
        .push_dat_i (p1_in),
        .head_dat_o (head1),
        .empty_o    (empty1),
        .full_o     (full1)
    );

    // Round-robin only matters when both queues hold work; otherwise the lone requester wins.
    assign sel      = (!empty0 && !empty1) ? ~last_q : !empty1;
    assign start    = (state_q == IDLE) && (!empty0 || !empty1);
    assign pop0     = start && !sel;
    assign pop1     = start && sel;
    assign head_sel = sel ? head1 : head0;
    assign ovf0     = p0_req_valid && full0 && !pop0;
    assign ovf1     = p1_req_valid && full1 && !pop1;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            last_q          <= 1'b1;
            grant_q         <= 1'b0;
            busy_q          <= 1'b0;
            overflow_q      <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_data_q  <= '0;
            mem_req_rw_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            p0_res_data_q   <= '0;
            p1_res_data_q   <= '0;
            p0_res_ready_q  <= 1'b0;
            p1_res_ready_q  <= 1'b0;
        end else begin
            p0_res_ready_q <= 1'b0;
            p1_res_ready_q <= 1'b0;
            if (ovf0 || ovf1) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mem_req_addr_q  <= head_sel.addr;
                        mem_req_data_q  <= head_sel.data;
                        mem_req_rw_q    <= head_sel.rw;
                        mem_req_valid_q <= 1'b1;
                        grant_q         <= sel;
                        last_q          <= sel;
                        busy_q          <= 1'b1;
                        state_q         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    // Write-back acks terminate here; only fills are returned to the L1.
                    if (mem_res_valid) begin
                        if (mem_req_rw_q) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            if (grant_q) begin
                                p1_res_data_q  <= mem_res_data;
                                p1_res_ready_q <= 1'b1;
                            end else begin
                                p0_res_data_q  <= mem_res_data;
                                p0_res_ready_q <= 1'b1;
                            end
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_data  = mem_req_data_q;
    assign mem_req_rw    = mem_req_rw_q;
    assign mem_req_valid = mem_req_valid_q;
    assign p0_res_data   = p0_res_data_q;
    assign p1_res_data   = p1_res_data_q;
    assign p0_res_ready  = p0_res_ready_q;
    assign p1_res_ready  = p1_res_ready_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: directed scenarios plus a randomized phase checked against a queue-based reference model.
module tb_l2_port_arbiter;
    localparam int AW    = 27;
    localparam int LW    = 128;
    localparam int DEPTH = 2;

    logic          sys_clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] p0_req_addr, p1_req_addr, mem_req_addr;
    logic [LW-1:0] p0_req_data, p1_req_data, p0_res_data, p1_res_data;
    logic [LW-1:0] mem_req_data, mem_res_data;
    logic          p0_req_rw, p1_req_rw, p0_req_valid, p1_req_valid;
    logic          p0_res_ready, p1_res_ready;
    logic          mem_req_rw, mem_req_valid, mem_req_ready, mem_res_valid;
    logic          grant, busy, overflow;

    always #5 sys_clk = ~sys_clk;

    l2_port_arbiter dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .p0_req_addr   (p0_req_addr),
        .p0_req_data   (p0_req_data),
        .p0_req_rw     (p0_req_rw),
        .p0_req_valid  (p0_req_valid),
        .p1_req_addr   (p1_req_addr),
        .p1_req_data   (p1_req_data),
        .p1_req_rw     (p1_req_rw),
        .p1_req_valid  (p1_req_valid),
        .p0_res_data   (p0_res_data),
        .p0_res_ready  (p0_res_ready),
        .p1_res_data   (p1_res_data),
        .p1_res_ready  (p1_res_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_rw    (mem_req_rw),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_res_data  (mem_res_data),
        .mem_res_valid (mem_res_valid),
        .grant         (grant),
        .busy          (busy),
        .overflow      (overflow)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic          rw;
    } req_s;

    req_s q0[$];
    req_s q1[$];
    int   grant_log[$];

    int checks = 0;
    int errors = 0;
    bit last_m, ovf_exp, busy_exp, clear_next, in_wait, res_real, prev_valid, noise_en, fixed_en;
    int timer, fixed_delay, ready_mode, txn_cnt, pulses0, pulses1;
    logic [LW-1:0] exp_dat0, exp_dat1, fixed_dat, resp_dat, cap_data;
    logic [AW-1:0] cap_addr;
    logic          cur_port, cur_rw;

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last_m     = 1'b1;
        ovf_exp    = 1'b0;
        busy_exp   = 1'b0;
        clear_next = 1'b0;
        in_wait    = 1'b0;
        res_real   = 1'b0;
        prev_valid = 1'b0;
        exp_dat0   = '0;
        exp_dat1   = '0;
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0:       mem_req_ready = 1'b1;
            1:       mem_req_ready = 1'($urandom_range(0, 1));
            default: mem_req_ready = 1'b0;
        endcase
    endtask

    // One clock: observe outputs 1 time unit after the edge, update the model, then drive the next edge.
    task automatic step();
        req_s h;
        bit   e0, e1, ex0, ex1;
        logic gp;
        @(posedge sys_clk);
        #1;
        ex0 = 1'b0;
        ex1 = 1'b0;
        if (clear_next) begin
            busy_exp   = 1'b0;
            clear_next = 1'b0;
        end
        if (res_real) begin
            in_wait  = 1'b0;
            res_real = 1'b0;
            if (!cur_rw) begin
                if (cur_port) begin ex1 = 1'b1; exp_dat1 = resp_dat; end
                else          begin ex0 = 1'b1; exp_dat0 = resp_dat; end
                clear_next = 1'b1;
            end else begin
                busy_exp = 1'b0;
            end
        end
        if (prev_valid) begin
            if (mem_req_ready) begin
                chk("accept_valid_drop", mem_req_valid, 0);
                in_wait = 1'b1;
                timer   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
            end else begin
                chk("hold_valid", mem_req_valid, 1);
                chk("hold_addr", mem_req_addr, cap_addr);
                chk("hold_data", mem_req_data, cap_data);
                chk("hold_rw", mem_req_rw, cur_rw);
            end
        end else if (mem_req_valid) begin
            e0 = (q0.size() > 0);
            e1 = (q1.size() > 0);
            chk("req_has_source", e0 || e1, 1);
            if (e0 || e1) begin
                gp     = (e0 && e1) ? ~last_m : e1;
                last_m = gp;
                h      = gp ? q1.pop_front() : q0.pop_front();
                chk("grant", grant, gp);
                chk("req_addr", mem_req_addr, h.addr);
                chk("req_data", mem_req_data, h.data);
                chk("req_rw", mem_req_rw, h.rw);
                grant_log.push_back(int'(grant));
                cur_port = gp;
                cur_rw   = h.rw;
                cap_addr = h.addr;
                cap_data = h.data;
                busy_exp = 1'b1;
                txn_cnt++;
            end
        end
        if (p0_req_valid) begin
            if (q0.size() < DEPTH) q0.push_back('{p0_req_addr, p0_req_data, p0_req_rw});
            else ovf_exp = 1'b1;
        end
        if (p1_req_valid) begin
            if (q1.size() < DEPTH) q1.push_back('{p1_req_addr, p1_req_data, p1_req_rw});
            else ovf_exp = 1'b1;
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        chk("overflow", overflow, ovf_exp);
        chk("p0_res_ready", p0_res_ready, ex0);
        chk("p1_res_ready", p1_res_ready, ex1);
        chk("p0_res_data", p0_res_data, exp_dat0);
        chk("p1_res_data", p1_res_data, exp_dat1);
        chk("busy", busy, busy_exp);
        pulses0 += int'(p0_res_ready);
        pulses1 += int'(p1_res_ready);
        prev_valid = mem_req_valid;
        drive_ready();
        mem_res_valid = 1'b0;
        if (in_wait) begin
            if (timer == 0) begin
                resp_dat      = fixed_en ? fixed_dat : rnd_line();
                mem_res_data  = resp_dat;
                mem_res_valid = 1'b1;
                res_real      = 1'b1;
            end else begin
                timer--;
            end
        end else if (noise_en && $urandom_range(0, 7) == 0) begin
            mem_res_valid = 1'b1;
            mem_res_data  = rnd_line();
        end
    endtask

    task automatic drain(input int lim);
        int  n;
        bit  pend;
        n    = 0;
        pend = 1'b1;
        while (pend && n < lim) begin
            step();
            n++;
            pend = (q0.size() > 0) || (q1.size() > 0) || busy_exp || in_wait || prev_valid || res_real || clear_next;
        end
        chk("drain_timeout", pend, 0);
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_req_addr, 0);
        chk("rst_mem_data", mem_req_data, 0);
        chk("rst_mem_rw", mem_req_rw, 0);
        chk("rst_p0_ready", p0_res_ready, 0);
        chk("rst_p1_ready", p1_res_ready, 0);
        chk("rst_p0_data", p0_res_data, 0);
        chk("rst_p1_data", p1_res_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        p0_req_valid  = 1'b0;
        p1_req_valid  = 1'b0;
        mem_res_valid = 1'b1;
        mem_res_data  = rnd_line();
        repeat (2) @(posedge sys_clk);
        #3 rstn = 1'b1;
        mem_res_valid = 1'b0;
        res_real      = 1'b0;
        drive_ready();
    endtask

    task automatic pulse(input bit port, input logic [AW-1:0] a, input logic rw);
        if (port) begin
            p1_req_addr = a; p1_req_rw = rw; p1_req_data = rnd_line(); p1_req_valid = 1'b1;
        end else begin
            p0_req_addr = a; p0_req_rw = rw; p0_req_data = rnd_line(); p0_req_valid = 1'b1;
        end
    endtask

    initial begin
        int b0, b1, bt, gl, n;
        rstn = 1'b1;
        p0_req_addr = '0; p0_req_data = '0; p0_req_rw = 1'b0; p0_req_valid = 1'b0;
        p1_req_addr = '0; p1_req_data = '0; p1_req_rw = 1'b0; p1_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_res_valid = 1'b0; mem_res_data = '0;
        fixed_delay = -1; ready_mode = 0; noise_en = 1'b0; fixed_en = 1'b0;
        txn_cnt = 0; pulses0 = 0; pulses1 = 0;
        fixed_dat = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
        do_reset();

        // Single fill on port 0 with a fixed response three cycles after acceptance.
        fixed_en = 1'b1; fixed_delay = 2;
        b0 = pulses0; b1 = pulses1; bt = txn_cnt;
        pulse(0, 27'h00000A8, 1'b0);
        step();
        chk("t1_valid_e0", mem_req_valid, 0);
        step();
        chk("t1_valid_e1", mem_req_valid, 1);
        chk("t1_addr", mem_req_addr, 27'h00000A8);
        drain(100);
        chk("t1_p0_data", p0_res_data, 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF);
        chk("t1_p0_pulses", pulses0 - b0, 1);
        chk("t1_p1_pulses", pulses1 - b1, 0);
        chk("t1_txns", txn_cnt - bt, 1);

        // Write-back followed next cycle by its fill on port 1.
        fixed_en = 1'b0; fixed_delay = 1;
        b0 = pulses0; b1 = pulses1; bt = txn_cnt;
        pulse(1, 27'h0000100, 1'b1);
        step();
        pulse(1, 27'h0000200, 1'b0);
        step();
        drain(100);
        chk("t2_p1_pulses", pulses1 - b1, 1);
        chk("t2_p0_pulses", pulses0 - b0, 0);
        chk("t2_txns", txn_cnt - bt, 2);

        // Simultaneous requests after reset: port 0 first; after a lone p0 grant, port 1 first.
        do_reset();
        gl = grant_log.size();
        pulse(0, 27'h0000300, 1'b0);
        pulse(1, 27'h0000400, 1'b0);
        step();
        drain(100);
        chk("t3a_count", grant_log.size() - gl, 2);
        if (grant_log.size() >= gl + 2) begin
            chk("t3a_first", grant_log[gl], 0);
            chk("t3a_second", grant_log[gl + 1], 1);
        end
        pulse(0, 27'h0000500, 1'b0);
        step();
        drain(100);
        gl = grant_log.size();
        pulse(0, 27'h0000600, 1'b0);
        pulse(1, 27'h0000700, 1'b0);
        step();
        drain(100);
        chk("t3b_count", grant_log.size() - gl, 2);
        if (grant_log.size() >= gl + 2) begin
            chk("t3b_first", grant_log[gl], 1);
            chk("t3b_second", grant_log[gl + 1], 0);
        end

        // Overflow: port 1 stalled in flight, three back-to-back p0 pulses; the third is dropped.
        ready_mode = 2; drive_ready();
        pulse(1, 27'h0000800, 1'b0);
        step();
        step();
        chk("t4_stalled", mem_req_valid, 1);
        bt = txn_cnt;
        for (int i = 0; i < 3; i++) begin
            pulse(0, AW'(27'h0000900 + i), 1'b0);
            step();
        end
        chk("t4_overflow", overflow, 1);
        ready_mode = 0; drive_ready();
        drain(200);
        chk("t4_p0_txns", txn_cnt - bt, 2);
        chk("t4_sticky", overflow, 1);

        // Backpressure: ten cycles without ready, then acceptance on the first ready edge.
        do_reset();
        ready_mode = 2; drive_ready();
        pulse(0, 27'h1234567, 1'b1);
        step();
        step();
        repeat (10) step();
        chk("t5_valid_held", mem_req_valid, 1);
        chk("t5_addr_held", mem_req_addr, 27'h1234567);
        ready_mode = 0; drive_ready();
        step();
        chk("t5_accepted", mem_req_valid, 0);
        drain(100);

        // Reset while waiting for a fill; a late completion must be ignored.
        fixed_delay = 30;
        pulse(0, 27'h0000A00, 1'b0);
        step();
        n = 0;
        while (!in_wait && n < 50) begin step(); n++; end
        chk("t6_reach_wait", in_wait, 1);
        step();
        step();
        chk("t6_busy_before", busy, 1);
        b0 = pulses0;
        do_reset();
        mem_res_valid = 1'b1;
        mem_res_data  = rnd_line();
        repeat (3) step();
        chk("t6_busy_after", busy, 0);
        chk("t6_no_pulse", pulses0 - b0, 0);
        chk("t6_mem_valid", mem_req_valid, 0);

        // Randomized traffic with random ready, response delay and stray completions.
        fixed_delay = -1; ready_mode = 1; noise_en = 1'b1;
        repeat (1500) begin
            if ($urandom_range(0, 3) == 0) pulse(0, AW'($urandom()), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) pulse(1, AW'($urandom()), 1'($urandom_range(0, 1)));
            step();
        end
        noise_en = 1'b0; ready_mode = 0; drive_ready();
        drain(300);
        chk("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
